// File: rtl/ifid_stage.sv
// IF/ID pipeline stage.
// Fetched words land in a small skid FIFO. A registered inst_ready keeps the
// fetch handshake off the decode stall/flush timing. The head of the FIFO
// feeds the 64-bit ifid_reg that ID and the forwarding unit decode.
// There is no bypass path, so a word accepted on one edge reaches ifid_reg on
// the next edge at the earliest.
module ifid_stage #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inst_valid,
    input  logic [31:0]             inst_pc,
    input  logic [31:0]             inst_data,
    output logic                    inst_ready,
    input  logic                    stall,
    input  logic                    flush,
    output logic [63:0]             ifid_reg,
    output logic                    ifid_valid,
    output logic [$clog2(DEPTH):0]  buf_count,
    output logic [15:0]             bubble_cnt
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [63:0]     BUBBLE   = {32'h0, NOP_INSTR};
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [15:0]     CNT_MAX  = 16'hFFFF;

    // FIFO storage and bookkeeping. The count is one bit wider than the
    // pointers, so full and empty are never confused.
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inst_ready_q, inst_ready_d;

    // Pipeline register towards ID.
    logic [63:0]   ifid_reg_q, ifid_reg_d;
    logic          ifid_valid_q, ifid_valid_d;
    logic [15:0]   bubble_cnt_q, bubble_cnt_d;

    logic          push;
    logic          advance;
    logic          pop;

    // Handshake qualifiers. A flush kills both the incoming beat and the pop.
    always_comb begin
        push    = inst_valid & inst_ready_q & ~flush;
        advance = ~stall & ~flush;
        pop     = advance & (count_q != '0);
    end

    // FIFO next state. inst_ready looks ahead at the post-edge occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {inst_pc + PC_STEP, inst_data};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
        inst_ready_d = (count_d < FULL_CNT);
    end

    // ifid_reg next state: pop the head, insert a bubble, or hold under stall.
    always_comb begin
        ifid_reg_d   = ifid_reg_q;
        ifid_valid_d = ifid_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            // Squash bubbles are not counted as starvation bubbles.
            ifid_reg_d   = BUBBLE;
            ifid_valid_d = 1'b0;
        end else if (advance) begin
            if (pop) begin
                ifid_reg_d   = mem_q[rd_ptr_q];
                ifid_valid_d = 1'b1;
            end else begin
                ifid_reg_d   = BUBBLE;
                ifid_valid_d = 1'b0;
                if (bubble_cnt_q != CNT_MAX) begin
                    bubble_cnt_d = bubble_cnt_q + 16'd1;
                end
            end
        end
    end

    // State registers. An asynchronous reset drops every buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_ready_q <= 1'b0;
            ifid_reg_q   <= BUBBLE;
            ifid_valid_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_ready_q <= inst_ready_d;
            ifid_reg_q   <= ifid_reg_d;
            ifid_valid_q <= ifid_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign inst_ready = inst_ready_q;
    assign ifid_reg   = ifid_reg_q;
    assign ifid_valid = ifid_valid_q;
    assign buf_count  = count_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
